// File: rtl/shift_ex_unit.sv
// rtl/shift_ex_unit.sv - two-stage 64-bit LSL/LSR/ASR/ROR execution unit with NZC flags
module shift_ex_unit #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [5:0]       in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c
);

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    logic             r_s1_valid;
    logic [1:0]       r_s1_op;
    logic [5:0]       r_s1_shamt;
    logic [TAG_W-1:0] r_s1_tag;
    logic [WIDTH-1:0] r_s1_opnd;
    logic             r_s1_fill;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_result;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_n;
    logic             r_s2_z;
    logic             r_s2_c;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_pre;
    logic             w_fill;
    logic [WIDTH-1:0] w_lvl [0:6];
    logic [WIDTH-1:0] w_result;
    logic             w_carry;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;
    assign w_accept = in_valid && w_s1_adv && !flush;

    // LSL is done as a right shift on the mirrored operand
    assign w_pre  = (in_op == OP_LSL) ? bit_rev(in_a) : in_a;
    assign w_fill = (in_op == OP_ASR) ? in_a[WIDTH-1] : 1'b0;

    assign w_lvl[0] = r_s1_opnd;
    for (genvar k = 0; k < 6; k++) begin : g_lvl
        localparam int SH = 1 << k;
        assign w_lvl[k+1] = !r_s1_shamt[k] ? w_lvl[k] :
                            (r_s1_op == OP_ROR) ? {w_lvl[k][SH-1:0], w_lvl[k][WIDTH-1:SH]}
                                                : {{SH{r_s1_fill}}, w_lvl[k][WIDTH-1:SH]};
    end

    assign w_result = (r_s1_op == OP_LSL) ? bit_rev(w_lvl[6]) : w_lvl[6];

    // On the conditioned operand the last bit out is always bit shamt-1
    always_comb begin
        w_carry = 1'b0;
        if (r_s1_shamt == 6'd0)
            w_carry = 1'b0;
        else if (r_s1_op == OP_ROR)
            w_carry = w_result[WIDTH-1];
        else
            w_carry = r_s1_opnd[r_s1_shamt - 6'd1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 2'b00;
            r_s1_shamt <= 6'd0;
            r_s1_tag   <= '0;
            r_s1_opnd  <= '0;
            r_s1_fill  <= 1'b0;
        end else begin
            if (flush)
                r_s1_valid <= 1'b0;
            else if (w_accept)
                r_s1_valid <= 1'b1;
            else if (w_s1_adv)
                r_s1_valid <= 1'b0;
            if (w_accept) begin
                r_s1_op    <= in_op;
                r_s1_shamt <= in_shamt;
                r_s1_tag   <= in_tag;
                r_s1_opnd  <= w_pre;
                r_s1_fill  <= w_fill;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_tag    <= '0;
            r_s2_n      <= 1'b0;
            r_s2_z      <= 1'b0;
            r_s2_c      <= 1'b0;
        end else begin
            if (flush)
                r_s2_valid <= 1'b0;
            else if (w_s2_adv)
                r_s2_valid <= r_s1_valid;
            if (r_s1_valid && w_s2_adv && !flush) begin
                r_s2_result <= w_result;
                r_s2_tag    <= r_s1_tag;
                r_s2_n      <= w_result[WIDTH-1];
                r_s2_z      <= (w_result == '0);
                r_s2_c      <= w_carry;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_s2_result;
    assign out_tag    = r_s2_tag;
    assign out_n      = r_s2_n;
    assign out_z      = r_s2_z;
    assign out_c      = r_s2_c;

endmodule

// File: tb/tb_shift_ex_unit.sv
// tb/tb_shift_ex_unit.sv - directed-vector bench for shift_ex_unit
module tb_shift_ex_unit;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [5:0]  in_shamt;
    logic [1:0]  in_op;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;
    logic        out_n;
    logic        out_z;
    logic        out_c;

    int n_vec = 0;
    int n_err = 0;

    shift_ex_unit #(.WIDTH(64), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_n(out_n), .out_z(out_z), .out_c(out_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [63:0] a,
                         input logic [5:0] sh, input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_shamt = sh;
        in_tag   = tag;
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input logic [63:0] a,
                         input logic [5:0] sh, input logic [4:0] tag,
                         input logic [63:0] e_res, input logic e_n, input logic e_z, input logic e_c);
        drive(op, a, sh, tag);
        @(negedge clk);
        in_valid = 1'b0;
        check({name, " valid@1"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check({name, " valid@2"}, {63'd0, out_valid}, 64'd1);
        check({name, " result"}, out_result, e_res);
        check({name, " tag"}, {59'd0, out_tag}, {59'd0, tag});
        check({name, " n"}, {63'd0, out_n}, {63'd0, e_n});
        check({name, " z"}, {63'd0, out_z}, {63'd0, e_z});
        check({name, " c"}, {63'd0, out_c}, {63'd0, e_c});
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_shamt = '0; in_op = '0; in_tag = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst out_valid", {63'd0, out_valid}, 64'd0);
        check("rst out_result", out_result, 64'd0);
        check("rst out_tag", {59'd0, out_tag}, 64'd0);
        check("rst flags", {61'd0, out_n, out_z, out_c}, 64'd0);
        check("rst in_ready", {63'd0, in_ready}, 64'd1);

        do_op("lsr1", LSR, 64'h8000_0000_0000_0001, 6'd1, 5'd3, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
        do_op("asr63", ASR, 64'hF000_0000_0000_0000, 6'd63, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
        do_op("lsl63", LSL, 64'h1, 6'd63, 5'd5, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0);
        do_op("lsr63", LSR, 64'h8000_0000_0000_0000, 6'd63, 5'd6, 64'h1, 1'b0, 1'b0, 1'b0);
        do_op("lsl4", LSL, 64'hF000_0000_0000_0001, 6'd4, 5'd7, 64'h10, 1'b0, 1'b0, 1'b1);
        do_op("ror4", ROR, 64'hF1, 6'd4, 5'd8, 64'h1000_0000_0000_000F, 1'b0, 1'b0, 1'b0);
        do_op("asr4pos", ASR, 64'h7000_0000_0000_0008, 6'd4, 5'd9, 64'h0700_0000_0000_0000, 1'b0, 1'b0, 1'b1);
        do_op("lsl0", LSL, 64'hDEAD_BEEF_0123_4567, 6'd0, 5'd10, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 1'b0);
        do_op("lsr0", LSR, 64'hDEAD_BEEF_0123_4567, 6'd0, 5'd11, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 1'b0);
        do_op("asr0", ASR, 64'hDEAD_BEEF_0123_4567, 6'd0, 5'd12, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 1'b0);
        do_op("ror0", ROR, 64'hDEAD_BEEF_0123_4567, 6'd0, 5'd13, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 1'b0);

        // back-to-back stream: op t returns value t+1 with tag t two cycles later
        for (int t = 0; t < 10; t++) begin
            if (t >= 2) begin
                check($sformatf("b2b valid t%0d", t), {63'd0, out_valid}, 64'd1);
                check($sformatf("b2b tag t%0d", t), {59'd0, out_tag}, 64'(t - 2));
                check($sformatf("b2b result t%0d", t), out_result, 64'(t - 1));
            end
            if (t < 8) drive(LSR, 64'(t + 1) << 4, 6'd4, 5'(t));
            else in_valid = 1'b0;
            @(negedge clk);
        end
        check("drain", {63'd0, out_valid}, 64'd0);

        // stall: two accepts fill both stages, then in_ready drops
        out_ready = 1'b0;
        check("stall rdy0", {63'd0, in_ready}, 64'd1);
        drive(LSR, 64'h90, 6'd4, 5'd8);
        @(negedge clk);
        check("stall rdy1", {63'd0, in_ready}, 64'd1);
        drive(LSR, 64'hA0, 6'd4, 5'd9);
        @(negedge clk);
        check("stall rdy2", {63'd0, in_ready}, 64'd0);
        check("stall valid2", {63'd0, out_valid}, 64'd1);
        check("stall tag2", {59'd0, out_tag}, 64'd8);
        drive(LSR, 64'hB0, 6'd4, 5'd10);
        @(negedge clk);
        check("stall rdy3", {63'd0, in_ready}, 64'd0);
        check("stall valid3", {63'd0, out_valid}, 64'd1);
        check("stall tag3", {59'd0, out_tag}, 64'd8);
        check("stall result3", out_result, 64'd9);

        // flush with both stages full and an input presented
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush valid", {63'd0, out_valid}, 64'd0);
        check("flush rdy", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("flush drop1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("flush drop2", {63'd0, out_valid}, 64'd0);
        do_op("lsrz", LSR, 64'h1, 6'd1, 5'd11, 64'h0, 1'b0, 1'b1, 1'b1);

        // reset while an op sits in S1
        drive(LSR, 64'h1, 6'd1, 5'd5);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst valid", {63'd0, out_valid}, 64'd0);
        check("mrst result", out_result, 64'd0);
        check("mrst tag", {59'd0, out_tag}, 64'd0);
        check("mrst flags", {61'd0, out_n, out_z, out_c}, 64'd0);
        @(negedge clk);
        check("mrst valid+1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("mrst valid+2", {63'd0, out_valid}, 64'd0);
        check("mrst rdy", {63'd0, in_ready}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_ex_unit.md
Name: shift_ex_unit

Overview:
- Two-stage pipelined 64-bit shift execution unit in the EX stage. It sits directly upstream of the writeback/forwarding mux.
- Takes a decoded shift micro-op (operand, 6-bit shamt, op select, destination tag) from the ID/EX register.
- Performs LSL/LSR/ASR/ROR through a single right-shift datapath built from 6 conditional shift levels (1,2,4,8,16,32), with bit-reversal for LSL.
- Produces a registered result plus NZC flags under valid/ready backpressure, with a flush for branch mispredicts.

Parameters:
- WIDTH, 64, datapath width; must be 64 (shamt width fixed at 6).
- TAG_W, 5, destination register tag width.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of all in-flight ops
- in_valid  input  1  micro-op present
- in_ready  output  1  unit can accept this cycle
- in_a  input  64  operand
- in_shamt  input  6  shift amount 0..63
- in_op  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- in_tag  input  TAG_W  destination register
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts
- out_result  output  64  shifted value
- out_tag  output  TAG_W  tag of result
- out_n  output  1  out_result[63]
- out_z  output  1  out_result == 0
- out_c  output  1  last bit shifted out

Behaviour:
- Reset: s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_tag=0, out_n=0, out_z=0, out_c=0. in_ready=1 from the first cycle after reset.
- Handshakes: input transfers when in_valid&&in_ready; output transfers when out_valid&&out_ready. Latency is exactly 2 cycles from accept to out_valid when there is no stall.
- Stage 1 (S1) register: on accept, capture in_op, in_shamt, in_tag and the pre-conditioned operand. The operand is bit-reversed for LSL and passed as-is otherwise. Also capture the fill bit: in_a[63] for ASR, 0 for all other ops.
- S1 to S2 compute: 6 cascaded levels. Level k shifts right by 2^k when shamt[k]=1.
  - Vacated bits take the fill bit for LSL/LSR/ASR.
  - Vacated bits take the wrapped-around low bits for ROR.
  - The LSL result is bit-reversed back afterwards.
- S2 register: holds out_result, out_tag and the flags. out_n and out_z are computed from the final result.
- out_c:
  - shamt=0: 0 for every op.
  - LSR/ASR: a[shamt-1].
  - LSL: a[64-shamt].
  - ROR: out_result[63].
- Pipeline control (no bubbles under continuous flow):
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - S2 loads when s1_valid&&s2_adv.
  - S1 loads on an input accept; otherwise it clears its valid when it advances.
- Stall: while out_valid&&!out_ready, S2 holds all outputs stable. S1 also holds if it is full, and in_ready=0 only when both stages are full.
- Full throughput: 1 op/cycle when out_ready is held high.
- Flush: next cycle s1_valid=0 and s2_valid=0. An input presented in the flush cycle is dropped; in_ready stays as computed. Flush overrides out_ready. Data registers need not clear.
- Reset mid-operation behaves as flush and also zeros the output data registers.
- shamt=0: out_result = in_a for all ops.
- shamt=63:
  - LSR: result is a[63] in bit 0.
  - ASR: all bits equal the sign.
  - LSL: result is a[0] in bit 63.
- No X propagation: when a valid is 0, the data registers may hold stale values, but out_* never go X after reset.

Test Plan:
- Reset, then LSR a=0x8000_0000_0000_0001, shamt=1, tag=3 -> 2 cycles later out_valid=1, result=0x4000_0000_0000_0000, tag=3, c=1, n=0, z=0.
- ASR a=0xF000_0000_0000_0000, shamt=63 -> result=0xFFFF_FFFF_FFFF_FFFF, n=1, c=1. LSL a=1, shamt=63 -> result=0x8000_0000_0000_0000, c=0.
- ROR a=0x0000_0000_0000_00F1, shamt=4 -> result=0x1000_0000_0000_000F, c=0. Also shamt=0 with each op -> result=a, c=0.
- Back-to-back 8 ops with out_ready=1 -> 8 results on 8 consecutive cycles, in order, tags 0..7. Then hold out_ready=0 for 3 cycles -> in_ready drops after 2 more accepts, and outputs stay stable.
- With both stages full, assert flush together with in_valid -> next cycle out_valid=0, no result for the dropped ops, and the following op completes normally 2 cycles after accept.
- LSR a=0x1, shamt=1 -> result=0, z=1, c=1. Assert reset while that op is in S1 -> out_valid stays 0 and all outputs read 0.
